// File: rtl/dpm_pkg.sv
// Shared DPM definitions: arbiter state encodings and a constant-width helper.
package dpm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// In-order channel-tag FIFO; push ignored when full, pop ignored when empty.
module tag_fifo
  import dpm_pkg::*;
#(
  parameter  int W     = 2,
  parameter  int DEPTH = 8,
  localparam int PW    = clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [PW:0]   o_count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign o_full  = (o_count == (PW+1)'(DEPTH));
  assign o_empty = (o_count == '0);
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;
  assign o_data  = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   o_count <= o_count + (PW+1)'(1);
        2'b01:   o_count <= o_count - (PW+1)'(1);
        default: o_count <= o_count;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_data;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among NUM_CH requesters, with in-order
// channel tagging of results and an enable-driven IDLE/RUN/DRAIN controller.
module adder_arbiter
  import dpm_pkg::*;
#(
  parameter  int DATA_WIDTH   = 32,
  parameter  int RESULT_WIDTH = 33,
  parameter  int NUM_CH       = 4,
  parameter  int TAG_DEPTH    = 8,
  localparam int CW           = clog2(NUM_CH)
) (
  input  logic                         i_clk,
  input  logic                         i_resetn,
  input  logic                         i_enable,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_req_data_a,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_req_data_b,
  input  logic [NUM_CH-1:0]            i_req_valid,
  output logic [NUM_CH-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]        o_add_data_a,
  output logic [DATA_WIDTH-1:0]        o_add_data_b,
  output logic                         o_add_valid,
  input  logic [RESULT_WIDTH-1:0]      i_add_data,
  input  logic                         i_add_valid,
  output logic [RESULT_WIDTH-1:0]      o_res_data,
  output logic [CW-1:0]                o_res_ch,
  output logic                         o_res_valid,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int PW = clog2(TAG_DEPTH);

  state_t                              state, state_nxt;
  logic [CW-1:0]                       rr_ptr, gnt_idx;
  logic [CW:0]                         cand;
  logic                                found, issue_ok, hs, pop;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]   req_a, req_b;
  logic                                fifo_full, fifo_empty;
  logic [CW-1:0]                       fifo_tag;
  logic [PW:0]                         fifo_count;

  assign req_a    = i_req_data_a;
  assign req_b    = i_req_data_b;
  assign issue_ok = (state == ST_RUN) & i_enable & ~fifo_full;
  assign hs       = issue_ok & found;
  assign pop      = i_add_valid & ~fifo_empty;
  assign o_busy   = (state != ST_IDLE);

  // First requester at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    found       = 1'b0;
    gnt_idx     = '0;
    cand        = '0;
    o_req_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr_ptr} + (CW+1)'(i);
      if (cand >= (CW+1)'(NUM_CH)) cand = cand - (CW+1)'(NUM_CH);
      if (!found && i_req_valid[cand[CW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[CW-1:0];
      end
    end
    if (issue_ok && found) o_req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (i_enable) state_nxt = ST_RUN;
      ST_RUN:   if (!i_enable) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (i_enable)                                 state_nxt = ST_RUN;
        else if (fifo_count == '0 && !i_add_valid)    state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      o_add_valid  <= 1'b0;
      o_add_data_a <= '0;
      o_add_data_b <= '0;
      o_res_valid  <= 1'b0;
      o_res_data   <= '0;
      o_res_ch     <= '0;
      o_err        <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_add_valid <= hs;
      if (hs) begin
        o_add_data_a <= req_a[gnt_idx];
        o_add_data_b <= req_b[gnt_idx];
        rr_ptr       <= (gnt_idx == CW'(NUM_CH-1)) ? '0 : gnt_idx + CW'(1);
      end
      o_res_valid <= pop;
      if (pop) begin
        o_res_data <= i_add_data;
        o_res_ch   <= fifo_tag;
      end
      if (i_add_valid && fifo_empty) o_err <= 1'b1;
    end
  end

  tag_fifo #(.W(CW), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_push   (hs),
    .i_data   (gnt_idx),
    .i_pop    (pop),
    .o_data   (fifo_tag),
    .o_full   (fifo_full),
    .o_empty  (fifo_empty),
    .o_count  (fifo_count)
  );

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized bench for adder_arbiter: queue-based adder model plus a
// transaction-level reference of grants, tags, state and error.
module tb_adder_arbiter;
  localparam int DW = 32, RW = 33, N = 4, TD = 8, CW = 2;

  logic              i_clk, i_resetn, i_enable;
  logic [N*DW-1:0]   i_req_data_a, i_req_data_b;
  logic [N-1:0]      i_req_valid, o_req_ready;
  logic [DW-1:0]     o_add_data_a, o_add_data_b;
  logic              o_add_valid, i_add_valid;
  logic [RW-1:0]     i_add_data, o_res_data;
  logic [CW-1:0]     o_res_ch;
  logic              o_res_valid, o_busy, o_err;

  adder_arbiter #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .NUM_CH(N), .TAG_DEPTH(TD)) dut (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_enable(i_enable),
    .i_req_data_a(i_req_data_a), .i_req_data_b(i_req_data_b),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .o_add_data_a(o_add_data_a), .o_add_data_b(o_add_data_b), .o_add_valid(o_add_valid),
    .i_add_data(i_add_data), .i_add_valid(i_add_valid),
    .o_res_data(o_res_data), .o_res_ch(o_res_ch), .o_res_valid(o_res_valid),
    .o_busy(o_busy), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [RW-1:0] sext(input logic [DW-1:0] v);
    return {{(RW-DW){v[DW-1]}}, v};
  endfunction

  // Adder: one cycle of latency, in order, can be stalled or forced to glitch.
  logic [RW-1:0] addq[$];
  bit            stall = 0, inject = 0;
  int            release_n = 0;

  initial begin
    i_add_valid = 1'b0;
    i_add_data  = '0;
    forever begin
      @(posedge i_clk); #1;
      i_add_valid = 1'b0;
      if (!i_resetn) addq.delete();
      else begin
        if (inject) begin
          i_add_valid = 1'b1;
          i_add_data  = 33'h1234;
          inject      = 0;
        end else if (addq.size() > 0 && (!stall || release_n > 0)) begin
          i_add_valid = 1'b1;
          i_add_data  = addq.pop_front();
          if (stall) release_n--;
        end
        if (o_add_valid) addq.push_back(sext(o_add_data_a) + sext(o_add_data_b));
      end
    end
  end

  // Reference model: decides the coming edge from inputs seen mid-cycle.
  typedef struct { int ch; logic [RW-1:0] sum; } tag_t;
  tag_t          expq[$];
  tag_t          t;
  int            out_n, mptr, issues = 0, g;
  bit            m_run, m_drain, m_err, res_pend, addv_exp, popd;
  logic [DW-1:0] ea, eb;
  logic [RW-1:0] er;
  logic [CW-1:0] ec;
  logic [N-1:0]  exp_ready;

  always @(negedge i_clk) begin
    if (!i_resetn) begin
      expq.delete();
      out_n = 0; mptr = 0; m_run = 0; m_drain = 0; m_err = 0;
      res_pend = 0; addv_exp = 0; ea = '0; eb = '0; er = '0; ec = '0;
    end else begin
      check("add_valid", o_add_valid, addv_exp);
      check("add_a", o_add_data_a, ea);
      check("add_b", o_add_data_b, eb);
      check("res_valid", o_res_valid, res_pend);
      check("res_data", o_res_data, er);
      check("res_ch", o_res_ch, ec);
      check("err", o_err, m_err);
      check("busy", o_busy, m_run || m_drain);

      g = -1;
      exp_ready = '0;
      if (m_run && i_enable && out_n < TD)
        for (int k = 0; k < N; k++)
          if (g < 0 && i_req_valid[(mptr + k) % N]) g = (mptr + k) % N;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", o_req_ready, exp_ready);

      popd = 0;
      res_pend = 0;
      if (i_add_valid) begin
        if (out_n > 0) begin
          t = expq.pop_front();
          popd = 1; res_pend = 1; er = t.sum; ec = CW'(t.ch);
        end else m_err = 1;
      end

      if (m_run) begin
        if (!i_enable) begin m_run = 0; m_drain = 1; end
      end else if (m_drain) begin
        if (i_enable) begin m_run = 1; m_drain = 0; end
        else if (out_n == 0 && !i_add_valid) m_drain = 0;
      end else if (i_enable) m_run = 1;

      addv_exp = (g >= 0);
      if (g >= 0) begin
        ea = i_req_data_a[g*DW +: DW];
        eb = i_req_data_b[g*DW +: DW];
        t.ch = g; t.sum = sext(ea) + sext(eb);
        expq.push_back(t);
        mptr = (g + 1) % N;
        issues++;
      end
      out_n = out_n + (g >= 0 ? 1 : 0) - (popd ? 1 : 0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic set_req(input logic [N-1:0] v);
    i_req_valid  = v;
    i_req_data_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    i_req_data_b = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  logic [RW-1:0] exp77;
  int base;

  initial begin
    exp77 = -77;
    i_resetn = 1'b0; i_enable = 1'b0;
    i_req_valid = '0; i_req_data_a = '0; i_req_data_b = '0;
    #2;
    check("rst_ready", o_req_ready, 0);
    check("rst_add_valid", o_add_valid, 0);
    check("rst_res_valid", o_res_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    @(posedge i_clk); #2 i_resetn = 1'b1;

    // single channel, one-cycle adder
    i_enable = 1'b1;
    tick(1);
    i_req_valid = 4'b0100;
    i_req_data_a[2*DW +: DW] = -32'sd100;
    i_req_data_b[2*DW +: DW] = 32'sd23;
    tick(1);
    i_req_valid = '0;
    tick(2);
    check("t1_res_valid", o_res_valid, 1);
    check("t1_res_data", o_res_data, exp77);
    check("t1_res_ch", o_res_ch, 2);
    tick(3);

    // all channels requesting continuously
    base = issues;
    repeat (8) begin set_req(4'hF); tick(1); end
    set_req(4'h0);
    check("burst_issues", issues - base, 8);
    tick(6);

    // adder stalled: tag FIFO fills, then one return frees one slot
    stall = 1;
    base = issues;
    repeat (12) begin set_req(4'hF); tick(1); end
    check("stall_issues", issues - base, 8);
    check("stall_ready", o_req_ready, 0);
    release_n = 1;
    tick(5);
    check("stall_one_more", issues - base, 9);
    set_req(4'h0);
    stall = 0;
    tick(15);

    // enable drop with three in flight
    stall = 1;
    base = issues;
    set_req(4'b0010); tick(3);
    set_req(4'h0);
    i_enable = 1'b0;
    stall = 0;
    for (int k = 0; k < 20 && o_busy; k++) tick(1);
    check("drain_idle", o_busy, 0);
    check("drain_issues", issues - base, 3);

    // result with nothing outstanding
    tick(2);
    inject = 1;
    tick(3);
    check("err_sticky", o_err, 1);
    tick(3);

    // random traffic
    i_enable = 1'b1;
    repeat (300) begin
      set_req(4'($urandom()));
      stall = ($urandom_range(3) == 0);
      if ($urandom_range(15) == 0) i_enable = ~i_enable;
      tick(1);
    end

    // reset in the middle of a burst
    i_enable = 1'b1; stall = 0;
    set_req(4'hF);
    tick(3);
    @(posedge i_clk); #3 i_resetn = 1'b0;
    #1;
    check("mid_rst_ready", o_req_ready, 0);
    check("mid_rst_add_valid", o_add_valid, 0);
    check("mid_rst_add_a", o_add_data_a, 0);
    check("mid_rst_res_valid", o_res_valid, 0);
    check("mid_rst_res_data", o_res_data, 0);
    check("mid_rst_err", o_err, 0);
    check("mid_rst_busy", o_busy, 0);
    @(posedge i_clk); @(posedge i_clk); #2 i_resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (o_req_ready != '0) break;
      tick(1);
    end
    check("post_rst_grant", o_req_ready, 4'b0001);
    tick(5);
    set_req(4'h0);
    tick(15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter sharing one `adder_with_valid` instance between NUM_CH independent requesters in the DPM datapath. It accepts operand pairs from the requesters over valid/ready handshakes and issues at most one pair per clock to the adder. Each result is tagged with its originating channel number from an in-order tag FIFO. An enable-driven state machine starts and stops issue cleanly and drains in-flight results before it reports idle.

## Interface
- DATA_WIDTH, 32, operand width (signed, two's complement)
- RESULT_WIDTH, 33, adder result width
- NUM_CH, 4, number of requesters (2..8)
- TAG_DEPTH, 8, tag FIFO depth; bounds operations in flight (power of 2)

- i_clk  in  1  clock
- i_resetn  in  1  asynchronous active-low reset
- i_enable  in  1  level; 1 = issue allowed
- i_req_data_a  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- i_req_data_b  in  NUM_CH*DATA_WIDTH  same packing
- i_req_valid  in  NUM_CH  per-channel request
- o_req_ready  out  NUM_CH  one-hot grant, combinational
- o_add_data_a / o_add_data_b  out  DATA_WIDTH  registered operands to adder
- o_add_valid  out  1  drives both i_valid_a and i_valid_b of adder
- i_add_data  in  RESULT_WIDTH  adder result
- i_add_valid  in  1  adder result valid
- o_res_data  out  RESULT_WIDTH  registered result
- o_res_ch  out  clog2(NUM_CH)  originating channel
- o_res_valid  out  1  single-cycle pulse; no backpressure
- o_busy  out  1  state != IDLE
- o_err  out  1  sticky: adder result arrived while the tag FIFO was empty

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN when i_enable=1.
  - RUN -> DRAIN when i_enable=0.
  - DRAIN -> IDLE when the tag FIFO is empty and i_add_valid=0.
  - DRAIN -> RUN when i_enable=1 again.
- Issue is allowed only in RUN with tag count < TAG_DEPTH. A pop in the same cycle does not free a slot for the push.
- Grant: the first channel with i_req_valid=1, searching from rr_ptr upward modulo NUM_CH. o_req_ready is one-hot on that channel and all-zero when issue is not allowed.
- On a handshake on channel g:
  - register its operands to o_add_data_a/b;
  - set o_add_valid=1;
  - push g to the tag FIFO;
  - set rr_ptr = (g+1) mod NUM_CH.
- With no handshake, o_add_valid=0, o_add_data_* hold their values, and rr_ptr holds.
- On i_add_valid=1:
  - pop the tag;
  - register i_add_data to o_res_data and the popped tag to o_res_ch;
  - pulse o_res_valid.
- If the FIFO is empty when i_add_valid=1: set o_err; o_res_valid stays 0.
- Push and pop in the same cycle leave the count unchanged.
- Results come out in issue order; the adder is required to be in-order.
- Reset values: all outputs 0 (o_req_ready=0, o_err=0); state IDLE; rr_ptr=0; FIFO empty. Reset asserted mid-operation discards tags for all in-flight operations.

## Timing
- Handshake sampled at edge k -> o_add_valid=1 in cycle k+1.
- i_add_valid sampled at edge m -> o_res_valid=1 in cycle m+1.
- End-to-end latency is adder latency + 2 cycles.
- Throughput: one issue per cycle. With all channels requesting, the grant order is 0,1,2,3,0,...
- i_enable falling: no grant in the same cycle (combinational on state and i_enable). Operations already issued still complete.

## Structure
- Shared package `dpm_pkg` holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DRAIN=2'd2;
  - the clog2 helper used for channel-ID and FIFO pointer widths.
- One sub-module, `tag_fifo`: synchronous FIFO with width clog2(NUM_CH), depth TAG_DEPTH, full/empty/count outputs and the same asynchronous active-low reset.
- Round-robin priority logic lives inline in `adder_arbiter`.

## Test plan
- Single channel: ch2 a=-100, b=23, enable=1, one-cycle adder -> o_res_data=-77, o_res_ch=2, o_res_valid 3 cycles after the handshake.
- All 4 channels valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; results emerge in the same channel order with correct sums.
- Adder stalled (i_add_valid=0) while all channels request -> exactly 8 issues, then o_req_ready=0. One result returned -> one further issue allowed on the following cycle.
- Drop i_enable with 3 operations in flight -> no new grants; o_busy stays 1 until the 3rd result, then IDLE.
- i_add_valid pulse with nothing issued -> o_err=1 and stays set; o_res_valid stays 0.
- Assert i_resetn=0 mid-burst -> all outputs 0 immediately. After release, the first grant goes to ch0.
